// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences a shared ALU/memory datapath,
// drives mux selects, write enables and alucontrol per state, stalls on
// mem_ready and counts retired instructions in instret.
// Optional build macro ILLEGAL_OP_TRAP_EN: unknown opcodes halt in HALT
// with illegal=1 until reset; otherwise they retire silently as a NOP.
module multicycle_controller #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic [2:0]       alucontrol,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t           state_q, state_d;
  logic [1:0]       aluop;
  logic             pcwrite, branch;
  logic             memwrite_raw, irwrite_raw, regwrite_raw;
  logic             retire;
  logic [CNT_W-1:0] instret_q;

  // State register; reset aborts any instruction back to FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d      = state_q;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
`ifdef ILLEGAL_OP_TRAP_EN
          default:      state_d = S_HALT;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
        state_d = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // ALU operation from aluop and, for R-type, funct
  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'h22:   alucontrol = 3'b110;
          6'h24:   alucontrol = 3'b000;
          6'h25:   alucontrol = 3'b001;
          6'h2A:   alucontrol = 3'b111;
          default: alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Retirement: last state of each real instruction heading back to FETCH
  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  // Enables are combinationally masked by reset so none survive its fall
  assign memwrite = memwrite_raw & reset;
  assign irwrite  = irwrite_raw & reset;
  assign regwrite = regwrite_raw & reset;
  assign pcen     = (pcwrite | (branch & zero)) & reset;
  assign state    = state_q;
  assign instret  = instret_q;

`ifdef ILLEGAL_OP_TRAP_EN
  assign illegal = (state_q == S_HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule
